// File: rtl/spi_flash_seq.sv
// Operation sequencer for the SPI flash command engine: expands a host request into the
// WREN / main command / RDSR-polling chain and reports completion, status and read data.
module spi_flash_seq #(
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 1000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [1:0]  op,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [23:0] op_addr,
  input  logic [7:0]  op_len,
  output logic        op_done,
  output logic        op_err,
  output logic [7:0]  status,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        wr_data_req,
  input  logic [7:0]  wr_data,
  output logic [7:0]  cmd,
  output logic        cmd_valid,
  output logic [23:0] cmd_addr,
  output logic [7:0]  cmd_size,
  input  logic        ack_cmd,
  input  logic        eng_data_req,
  output logic [7:0]  eng_data_in,
  input  logic [7:0]  eng_data_out,
  input  logic        eng_data_valid
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_PP   = 2'd1;
  localparam logic [1:0] OP_SE   = 2'd2;

  localparam logic [7:0] C_WREN = 8'h06;
  localparam logic [7:0] C_RDSR = 8'h05;
  localparam logic [7:0] C_READ = 8'h03;
  localparam logic [7:0] C_PP   = 8'h02;
  localparam logic [7:0] C_SE   = 8'hD8;
  localparam logic [7:0] C_BE   = 8'hC7;

  typedef enum logic [3:0] {
    S_IDLE, S_ISSUE_WREN, S_WAIT_WREN, S_ISSUE_OP, S_WAIT_OP,
    S_GAP, S_ISSUE_POLL, S_WAIT_POLL, S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [23:0]   addr_q;
  logic [7:0]    len_q;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic [7:0]    poll_byte;

  function automatic logic op_reject(input logic [1:0] o, input logic [23:0] a,
                                     input logic [7:0] l);
    logic [8:0] end_pos;
    end_pos = {1'b0, a[7:0]} + {1'b0, l};
    if ((o == OP_READ || o == OP_PP) && l == 8'd0) return 1'b1;
    if (o == OP_PP && end_pos > 9'd256) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] main_opcode(input logic [1:0] o);
    case (o)
      OP_READ: return C_READ;
      OP_PP:   return C_PP;
      OP_SE:   return C_SE;
      default: return C_BE;
    endcase
  endfunction

  // The byte arriving with the poll ack must win over the previously captured status.
  assign poll_byte   = eng_data_valid ? eng_data_out : status;
  assign wr_data_req = eng_data_req;
  assign eng_data_in = wr_data;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_ready  <= 1'b1;
      op_done   <= 1'b0;
      op_err    <= 1'b0;
      status    <= 8'h00;
      rd_valid  <= 1'b0;
      rd_data   <= 8'h00;
      cmd_valid <= 1'b0;
      cmd       <= 8'h00;
      cmd_addr  <= 24'h0;
      cmd_size  <= 8'h00;
      gap_cnt   <= '0;
      poll_cnt  <= '0;
      op_q      <= 2'd0;
      addr_q    <= 24'h0;
      len_q     <= 8'h00;
    end else begin
      cmd_valid <= 1'b0;
      op_done   <= 1'b0;
      op_err    <= 1'b0;
      rd_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q     <= op;
            addr_q   <= op_addr;
            len_q    <= op_len;
            op_ready <= 1'b0;
            if (op_reject(op, op_addr, op_len)) begin
              state   <= S_DONE;
              op_done <= 1'b1;
              op_err  <= 1'b1;
            end else if (op == OP_READ) begin
              state     <= S_ISSUE_OP;
              cmd_valid <= 1'b1;
              cmd       <= C_READ;
              cmd_addr  <= op_addr;
              cmd_size  <= op_len;
            end else begin
              state     <= S_ISSUE_WREN;
              cmd_valid <= 1'b1;
              cmd       <= C_WREN;
              cmd_addr  <= 24'h0;
              cmd_size  <= 8'h00;
            end
          end
        end
        S_ISSUE_WREN: state <= S_WAIT_WREN;
        S_WAIT_WREN: begin
          if (ack_cmd) begin
            state     <= S_ISSUE_OP;
            cmd_valid <= 1'b1;
            cmd       <= main_opcode(op_q);
            cmd_addr  <= (op_q == OP_READ || op_q == OP_PP || op_q == OP_SE) ? addr_q : 24'h0;
            cmd_size  <= (op_q == OP_READ || op_q == OP_PP) ? len_q : 8'h00;
          end
        end
        S_ISSUE_OP: state <= S_WAIT_OP;
        S_WAIT_OP: begin
          if (eng_data_valid && op_q == OP_READ) begin
            rd_valid <= 1'b1;
            rd_data  <= eng_data_out;
          end
          if (ack_cmd) begin
            if (op_q == OP_READ) begin
              state   <= S_DONE;
              op_done <= 1'b1;
            end else begin
              state    <= S_GAP;
              gap_cnt  <= '0;
              poll_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state     <= S_ISSUE_POLL;
            gap_cnt   <= '0;
            cmd_valid <= 1'b1;
            cmd       <= C_RDSR;
            cmd_addr  <= 24'h0;
            cmd_size  <= 8'd1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_ISSUE_POLL: state <= S_WAIT_POLL;
        S_WAIT_POLL: begin
          if (eng_data_valid) status <= eng_data_out;
          if (ack_cmd) begin
            poll_cnt <= poll_cnt + 1'b1;
            if (!poll_byte[0]) begin
              state   <= S_DONE;
              op_done <= 1'b1;
            end else if (PW'(poll_cnt + 1'b1) == POLL_LAST) begin
              state   <= S_DONE;
              op_done <= 1'b1;
              op_err  <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with a small behavioural command-engine model.
module tb_spi_flash_seq;

  localparam int POLL_GAP = 4;
  localparam int POLL_MAX = 3;

  logic        sys_clk;
  logic        rst;
  logic [1:0]  op;
  logic        op_valid;
  logic        op_ready;
  logic [23:0] op_addr;
  logic [7:0]  op_len;
  logic        op_done;
  logic        op_err;
  logic [7:0]  status;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_data_req;
  logic [7:0]  wr_data;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_size;
  logic        ack_cmd;
  logic        eng_data_req;
  logic [7:0]  eng_data_in;
  logic [7:0]  eng_data_out;
  logic        eng_data_valid;

  logic eng_ack  = 1'b0;
  logic spur_ack = 1'b0;
  assign ack_cmd = eng_ack | spur_ack;

  spi_flash_seq #(.POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)) dut (
    .sys_clk(sys_clk), .rst(rst), .op(op), .op_valid(op_valid), .op_ready(op_ready),
    .op_addr(op_addr), .op_len(op_len), .op_done(op_done), .op_err(op_err),
    .status(status), .rd_data(rd_data), .rd_valid(rd_valid), .wr_data_req(wr_data_req),
    .wr_data(wr_data), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .ack_cmd(ack_cmd), .eng_data_req(eng_data_req),
    .eng_data_in(eng_data_in), .eng_data_out(eng_data_out), .eng_data_valid(eng_data_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] stat_seq [0:3];

  // Observation log and engine model, both on the falling edge.
  int          cyc = 0, n_cmd = 0, n_rd = 0, n_req = 0, n_done = 0, cv_dbl = 0;
  logic        last_err = 1'b0, prev_cv = 1'b0;
  logic [7:0]  log_cmd  [0:63];
  logic [23:0] log_addr [0:63];
  logic [7:0]  log_size [0:63];
  int          log_cyc  [0:63];
  logic [7:0]  log_rd   [0:63];
  logic        e_busy = 1'b0;
  logic [7:0]  e_op = 8'h00;
  int          e_cnt = 0, e_size = 0, poll_idx = 0;

  initial begin
    eng_data_out = 8'h00; eng_data_valid = 1'b0; eng_data_req = 1'b0;
  end

  always @(negedge sys_clk) begin
    cyc++;
    if (cmd_valid && n_cmd < 64) begin
      log_cmd[n_cmd] = cmd; log_addr[n_cmd] = cmd_addr;
      log_size[n_cmd] = cmd_size; log_cyc[n_cmd] = cyc;
    end
    if (cmd_valid) n_cmd++;
    if (cmd_valid && prev_cv) cv_dbl++;
    prev_cv = cmd_valid;
    if (rd_valid && n_rd < 64) log_rd[n_rd] = rd_data;
    if (rd_valid) n_rd++;
    if (wr_data_req) n_req++;
    if (op_done) begin n_done++; last_err = op_err; end

    eng_ack = 1'b0; eng_data_valid = 1'b0; eng_data_req = 1'b0;
    if (rst) begin
      e_busy = 1'b0;
    end else begin
      if (e_busy) begin
        case (e_op)
          8'h03: if (e_cnt < e_size) begin
                   eng_data_valid = 1'b1; eng_data_out = 8'hA0 + 8'(e_cnt); e_cnt++;
                 end else begin eng_ack = 1'b1; e_busy = 1'b0; end
          8'h02: if (e_cnt < e_size) begin eng_data_req = 1'b1; e_cnt++; end
                 else if (e_cnt == e_size) e_cnt++;
                 else begin eng_ack = 1'b1; e_busy = 1'b0; end
          8'h05: begin
                   eng_data_valid = 1'b1; eng_data_out = stat_seq[poll_idx];
                   if (poll_idx < 3) poll_idx++;
                   eng_ack = 1'b1; e_busy = 1'b0;
                 end
          default: if (e_cnt == 0) e_cnt++;
                   else begin eng_ack = 1'b1; e_busy = 1'b0; end
        endcase
      end
      if (cmd_valid) begin
        e_busy = 1'b1; e_op = cmd; e_size = int'(cmd_size); e_cnt = 0;
        if (cmd != 8'h05) poll_idx = 0;
      end
    end
  end

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [23:0] a, input logic [7:0] l);
    tick();
    op = o; op_addr = a; op_len = l; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int k;
    k = 0;
    while (n_done == base && k < budget) begin tick(); k++; end
    chk("done_seen", 32'(n_done - base), 32'd1);
  endtask

  int b_cmd, b_rd, b_req, b_done, k;

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 2'd0; op_addr = 24'h0; op_len = 8'h0; wr_data = 8'h3C;
    stat_seq[0] = 8'h01; stat_seq[1] = 8'h01; stat_seq[2] = 8'h00; stat_seq[3] = 8'h00;
    repeat (3) tick();
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_op_done", 32'(op_done), 32'd0);
    chk("rst_op_err", 32'(op_err), 32'd0);
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h00);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h00);
    chk("rst_cmd_addr", 32'(cmd_addr), 32'h0);
    chk("rst_cmd_size", 32'(cmd_size), 32'h0);
    rst = 1'b0;
    tick();
    chk("eng_data_in", 32'(eng_data_in), 32'h3C);

    // READ 0x001000 x4
    b_cmd = n_cmd; b_rd = n_rd; b_done = n_done;
    issue(2'd0, 24'h001000, 8'd4);
    chk("rd_op_ready_drop", 32'(op_ready), 32'd0);
    wait_done(b_done, 100);
    chk("rd_err", 32'(last_err), 32'd0);
    chk("rd_ncmd", 32'(n_cmd - b_cmd), 32'd1);
    chk("rd_cmd", 32'(log_cmd[b_cmd]), 32'h03);
    chk("rd_addr", 32'(log_addr[b_cmd]), 32'h001000);
    chk("rd_size", 32'(log_size[b_cmd]), 32'd4);
    chk("rd_nbytes", 32'(n_rd - b_rd), 32'd4);
    for (int i = 0; i < 4; i++) chk("rd_byte", 32'(log_rd[b_rd + i]), 32'(8'hA0 + i));

    // PAGE_PROG 0x0000F0 x16 (ends exactly on page boundary), status 01,01,00
    b_cmd = n_cmd; b_rd = n_rd; b_req = n_req; b_done = n_done;
    issue(2'd1, 24'h0000F0, 8'd16);
    wait_done(b_done, 300);
    chk("pp_err", 32'(last_err), 32'd0);
    chk("pp_ncmd", 32'(n_cmd - b_cmd), 32'd5);
    chk("pp_wren", 32'(log_cmd[b_cmd]), 32'h06);
    chk("pp_wren_size", 32'(log_size[b_cmd]), 32'd0);
    chk("pp_cmd", 32'(log_cmd[b_cmd + 1]), 32'h02);
    chk("pp_addr", 32'(log_addr[b_cmd + 1]), 32'h0000F0);
    chk("pp_size", 32'(log_size[b_cmd + 1]), 32'd16);
    chk("pp_nreq", 32'(n_req - b_req), 32'd16);
    for (int i = 2; i < 5; i++) begin
      chk("pp_rdsr", 32'(log_cmd[b_cmd + i]), 32'h05);
      chk("pp_rdsr_size", 32'(log_size[b_cmd + i]), 32'd1);
    end
    chk("pp_gap1", 32'(log_cyc[b_cmd + 3] - log_cyc[b_cmd + 2] >= POLL_GAP), 32'd1);
    chk("pp_gap2", 32'(log_cyc[b_cmd + 4] - log_cyc[b_cmd + 3] >= POLL_GAP), 32'd1);
    chk("pp_status", 32'(status), 32'h00);
    chk("pp_no_rd", 32'(n_rd - b_rd), 32'd0);

    // Page-crossing PAGE_PROG and zero-length READ are rejected without engine traffic
    b_cmd = n_cmd; b_done = n_done;
    issue(2'd1, 24'h0000F8, 8'd16);
    wait_done(b_done, 1);
    chk("xpg_err", 32'(last_err), 32'd1);
    b_done = n_done;
    issue(2'd0, 24'h000100, 8'd0);
    wait_done(b_done, 1);
    chk("len0_err", 32'(last_err), 32'd1);
    chk("rej_ncmd", 32'(n_cmd - b_cmd), 32'd0);

    // SECTOR_ERASE with WIP stuck: exactly POLL_MAX polls then timeout
    stat_seq[0] = 8'h01; stat_seq[1] = 8'h01; stat_seq[2] = 8'h01; stat_seq[3] = 8'h01;
    b_cmd = n_cmd; b_done = n_done;
    issue(2'd2, 24'h0A1000, 8'd0);
    wait_done(b_done, 300);
    chk("se_err", 32'(last_err), 32'd1);
    chk("se_ncmd", 32'(n_cmd - b_cmd), 32'd5);
    chk("se_wren", 32'(log_cmd[b_cmd]), 32'h06);
    chk("se_cmd", 32'(log_cmd[b_cmd + 1]), 32'hD8);
    chk("se_addr", 32'(log_addr[b_cmd + 1]), 32'h0A1000);
    chk("se_size", 32'(log_size[b_cmd + 1]), 32'd0);
    chk("se_rdsr_last", 32'(log_cmd[b_cmd + 4]), 32'h05);
    chk("se_status", 32'(status), 32'h01);
    repeat (15) tick();
    chk("se_no_extra_poll", 32'(n_cmd - b_cmd), 32'd5);

    // Spurious ack in IDLE changes nothing
    b_cmd = n_cmd; b_done = n_done;
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    repeat (3) tick();
    chk("spur_ready", 32'(op_ready), 32'd1);
    chk("spur_ncmd", 32'(n_cmd - b_cmd), 32'd0);
    chk("spur_ndone", 32'(n_done - b_done), 32'd0);
    chk("spur_status", 32'(status), 32'h01);

    // op_valid held high: one request per IDLE acceptance
    b_cmd = n_cmd; b_rd = n_rd; b_done = n_done;
    tick();
    op = 2'd0; op_addr = 24'h000020; op_len = 8'd1; op_valid = 1'b1;
    k = 0;
    while (n_done - b_done < 2 && k < 200) begin tick(); k++; end
    op_valid = 1'b0;
    repeat (10) tick();
    chk("hold_ndone", 32'(n_done - b_done), 32'd2);
    chk("hold_ncmd", 32'(n_cmd - b_cmd), 32'd2);
    chk("hold_nrd", 32'(n_rd - b_rd), 32'd2);

    // BULK_ERASE aborted by reset while waiting between polls
    b_cmd = n_cmd; b_done = n_done;
    issue(2'd3, 24'hFFFFFF, 8'd0);
    k = 0;
    while (n_cmd - b_cmd < 2 && k < 50) begin tick(); k++; end
    chk("be_two_cmds", 32'(n_cmd - b_cmd), 32'd2);
    chk("be_cmd", 32'(log_cmd[b_cmd + 1]), 32'hC7);
    chk("be_size", 32'(log_size[b_cmd + 1]), 32'd0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("be_rst_ready", 32'(op_ready), 32'd1);
    chk("be_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("be_rst_status", 32'(status), 32'h00);
    rst = 1'b0;
    repeat (10) tick();
    chk("be_no_done", 32'(n_done - b_done), 32'd0);
    chk("be_no_poll", 32'(n_cmd - b_cmd), 32'd2);

    b_cmd = n_cmd; b_rd = n_rd; b_done = n_done;
    issue(2'd0, 24'h000010, 8'd2);
    wait_done(b_done, 100);
    chk("post_err", 32'(last_err), 32'd0);
    chk("post_nrd", 32'(n_rd - b_rd), 32'd2);
    chk("post_byte1", 32'(log_rd[b_rd + 1]), 32'hA1);
    chk("cmd_valid_single", 32'(cv_dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
